// File: rtl/byte_serial_add_sub.sv
// byte_serial_add_sub: multi-byte two's-complement adder/subtractor.
// One byte per clock, LSB first, carry kept in a register between bytes.
// Start/Busy/Done handshake; Result and flags are registered and only
// change on the edge that enters DONE.
// Optional feature: define SAT_EN to clamp Result on signed overflow.
module byte_serial_add_sub #(
    parameter int BYTES = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Sub,
    input  logic [8*BYTES-1:0] OpA,
    input  logic [8*BYTES-1:0] OpB,
    output logic               Busy,
    output logic               Done,
    output logic [8*BYTES-1:0] Result,
    output logic               CarryOut,
    output logic               Overflow,
    output logic               Zero
);

    localparam int WIDTH = 8 * BYTES;
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // holds OpB already inverted for subtract
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [8:0]       sum9;
    logic [7:0]       low7;
    logic             ovf_next;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] out_word;
    logic             zero_next;

    // Select the current byte pair, add with carry and merge into the word
    always_comb begin
        a_byte    = '0;
        b_byte    = '0;
        word_next = work;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_byte = a_reg[i*8 +: 8];
                b_byte = b_reg[i*8 +: 8];
            end
        end
        sum9 = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
        // Carry into the byte's top bit; only meaningful on the final byte
        low7 = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'b0, carry};
        ovf_next = low7[7] ^ sum9[8];
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                word_next[i*8 +: 8] = sum9[7:0];
            end
        end
`ifdef SAT_EN
        if (ovf_next) begin
            out_word = {a_reg[WIDTH-1], {(WIDTH-1){~a_reg[WIDTH-1]}}};
        end else begin
            out_word = word_next;
        end
`else
        out_word = word_next;
`endif
        zero_next = (out_word == '0);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            work     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_reg <= OpA;
                        b_reg <= OpB ^ {WIDTH{Sub}};
                        carry <= Sub;
                        idx   <= '0;
                        state <= RUN;
                        Busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    work  <= word_next;
                    carry <= sum9[8];
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Result   <= out_word;
                        CarryOut <= sum9[8];
                        Overflow <= ovf_next;
                        Zero     <= zero_next;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add_sub.sv
// Directed bench for byte_serial_add_sub with BYTES = 4.
module tb_byte_serial_add_sub;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Sub;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic        CarryOut;
    logic        Overflow;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    byte_serial_add_sub #(.BYTES(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Sub      (Sub),
        .OpA      (OpA),
        .OpB      (OpB),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; Start is sampled on the next posedge (edge 0)
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        Sub   = s;
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        OpA   = 32'hDEAD_BEEF;
        OpB   = 32'hCAFE_F00D;
        Sub   = ~s;
    endtask

    // Called at the negedge after edge 0; ends at the negedge after edge 4
    task automatic wait_done(input string tag, input logic [31:0] er,
                             input logic ec, input logic ev, input logic ez);
        check({tag, " busy@0"}, {31'b0, Busy}, 32'd1);
        check({tag, " done@0"}, {31'b0, Done}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge Clk);
            check({tag, " busy@run"}, {31'b0, Busy}, 32'd1);
            check({tag, " done@run"}, {31'b0, Done}, 32'd0);
        end
        @(negedge Clk);
        check({tag, " done@4"}, {31'b0, Done}, 32'd1);
        check({tag, " busy@4"}, {31'b0, Busy}, 32'd0);
        check({tag, " result"}, Result, er);
        check({tag, " carry"}, {31'b0, CarryOut}, {31'b0, ec});
        check({tag, " ovf"}, {31'b0, Overflow}, {31'b0, ev});
        check({tag, " zero"}, {31'b0, Zero}, {31'b0, ez});
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic ec, input logic ev, input logic ez);
        launch(s, a, b);
        wait_done(tag, er, ec, ev, ez);
    endtask

    int done_seen;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Sub   = 1'b0;
        OpA   = '0;
        OpB   = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst busy", {31'b0, Busy}, 32'd0);
        check("rst done", {31'b0, Done}, 32'd0);
        check("rst result", Result, 32'h0);
        check("rst carry", {31'b0, CarryOut}, 32'd0);
        check("rst ovf", {31'b0, Overflow}, 32'd0);
        check("rst zero", {31'b0, Zero}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        run_op("add ff+1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("idle after done", {31'b0, Done}, 32'd0);
        run_op("sub 5-5", 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
`ifdef SAT_EN
        run_op("add maxpos+1", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        run_op("add maxpos+1", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge Clk);
        run_op("sub 0-1", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
`ifdef SAT_EN
        run_op("sub minneg-1", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        run_op("sub minneg-1", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        @(negedge Clk);

        // Start pulses on edges 2 and 3 are ignored
        launch(1'b0, 32'h0000_0010, 32'h0000_0020);
`ifdef SAT_EN
        check("ign held@0", Result, 32'h8000_0000);
`else
        check("ign held@0", Result, 32'h7FFF_FFFF);
`endif
        @(negedge Clk);
        Start = 1'b1;
        Sub   = 1'b1;
        OpA   = 32'hFFFF_FFFF;
        OpB   = 32'h1234_5678;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check("ign busy@3", {31'b0, Busy}, 32'd1);
`ifdef SAT_EN
        check("ign held@3", Result, 32'h8000_0000);
`else
        check("ign held@3", Result, 32'h7FFF_FFFF);
`endif
        @(negedge Clk);
        check("ign done", {31'b0, Done}, 32'd1);
        check("ign result", Result, 32'h0000_0030);
        check("ign carry", {31'b0, CarryOut}, 32'd0);
        @(negedge Clk);
        check("ign no queue busy", {31'b0, Busy}, 32'd0);
        check("ign no queue done", {31'b0, Done}, 32'd0);

        // Back-to-back: second Start is issued in the Done cycle
        run_op("b2b first", 1'b0, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 1'b0, 1'b0, 1'b0);
        run_op("b2b second", 1'b0, 32'h0F0F_0F0F, 32'h0101_0101, 32'h1010_1010, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);

        // Reset during the 2nd RUN cycle aborts the operation
        launch(1'b1, 32'h0000_0009, 32'h0000_0003);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort busy", {31'b0, Busy}, 32'd0);
        check("abort done", {31'b0, Done}, 32'd0);
        check("abort result", Result, 32'h0);
        check("abort carry", {31'b0, CarryOut}, 32'd0);
        check("abort ovf", {31'b0, Overflow}, 32'd0);
        check("abort zero", {31'b0, Zero}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        check("abort no done", done_seen, 32'd0);
        check("abort idle", {31'b0, Busy}, 32'd0);
        run_op("after abort", 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
